// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: synchronous successive-approximation controller for the SAR ADC macro.
// Sequences the sampling switch, cap-DAC bottom-plate drives and comparator strobe,
// resolves one bit per trial (MSB first) and hands the code out over valid/ready.
module sar_adc_ctrl #(
  parameter int unsigned NBITS         = 8,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             sample,
  output logic [NBITS-1:0] cap_drv,
  output logic             comp_strobe,
  input  logic             comp_out,
  output logic [NBITS-1:0] result,
  output logic             valid,
  input  logic             ready
);

  // One counter serves both the sampling window and the per-trial settle window.
  localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(NBITS);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(NBITS - 1);
  localparam logic [NBITS-1:0] BIT0        = {{(NBITS-1){1'b0}}, 1'b1};
  localparam logic [NBITS-1:0] BIT_MSB     = {1'b1, {(NBITS-1){1'b0}}};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_LATCH  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]       state_q,       state_d;
  logic [IDX_W-1:0] idx_q,         idx_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic             sample_q,      sample_d;
  logic [NBITS-1:0] cap_drv_q,     cap_drv_d;
  logic             comp_strobe_q, comp_strobe_d;
  logic             busy_q,        busy_d;
  logic             valid_q,       valid_d;
  logic [NBITS-1:0] result_q,      result_d;

  logic [NBITS-1:0] idx_onehot;
  logic [NBITS-1:0] cap_decided;

  // Trial-bit position and the DAC word with the current comparator decision folded in.
  always_comb begin
    idx_onehot  = BIT0 << idx_q;
    cap_decided = comp_out ? cap_drv_q : (cap_drv_q & ~idx_onehot);
  end

  // Next-state and next-output computation; abort overrides every state.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    sample_d      = sample_q;
    cap_drv_d     = cap_drv_q;
    comp_strobe_d = 1'b0;
    busy_d        = busy_q;
    valid_d       = valid_q;
    result_d      = result_q;

    if (abort) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      cnt_d     = '0;
      sample_d  = 1'b0;
      cap_drv_d = '0;
      busy_d    = 1'b0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_SAMPLE;
            idx_d     = IDX_MSB;
            cnt_d     = '0;
            sample_d  = 1'b1;
            cap_drv_d = '0;
            busy_d    = 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (cnt_q == SAMPLE_LAST) begin
            // Switch opens and the MSB trial drive asserts on the same edge,
            // so the two are never high together.
            state_d   = ST_SETTLE;
            cnt_d     = '0;
            sample_d  = 1'b0;
            cap_drv_d = BIT_MSB;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d       = ST_STROBE;
            cnt_d         = '0;
            comp_strobe_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_STROBE: begin
          state_d = ST_LATCH;
        end

        ST_LATCH: begin
          if (idx_q != '0) begin
            state_d   = ST_SETTLE;
            idx_d     = idx_q - 1'b1;
            cap_drv_d = cap_decided | (idx_onehot >> 1);
          end else begin
            state_d   = ST_DONE;
            cap_drv_d = cap_decided;
            result_d  = cap_decided;
            busy_d    = 1'b0;
            valid_d   = 1'b1;
          end
        end

        ST_DONE: begin
          if (ready) begin
            state_d   = ST_IDLE;
            cap_drv_d = '0;
            valid_d   = 1'b0;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          cnt_d     = '0;
          sample_d  = 1'b0;
          cap_drv_d = '0;
          busy_d    = 1'b0;
          valid_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset discards any conversion in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      sample_q      <= 1'b0;
      cap_drv_q     <= '0;
      comp_strobe_q <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      sample_q      <= sample_d;
      cap_drv_q     <= cap_drv_d;
      comp_strobe_q <= comp_strobe_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      result_q      <= result_d;
    end
  end

  assign busy        = busy_q;
  assign sample      = sample_q;
  assign cap_drv     = cap_drv_q;
  assign comp_strobe = comp_strobe_q;
  assign result      = result_q;
  assign valid       = valid_q;

  // Analog-side safety invariants.
  a_break_before_make: assert property (@(posedge clk) disable iff (!rst_n)
    !(sample_q && (cap_drv_q != '0)));
  a_strobe_single: assert property (@(posedge clk) disable iff (!rst_n)
    comp_strobe_q |=> !comp_strobe_q);
  a_valid_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    valid_q |-> !busy_q);

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: two instances (default parameters and a 4-bit sweep),
// an ideal comparator, and a timeline model of the conversion checked every cycle.
module tb_sar_adc_ctrl;

  localparam int unsigned N0 = 8, S0 = 2, T0 = 1;
  localparam int unsigned N1 = 4, S1 = 3, T1 = 2;
  localparam int unsigned M_IDLE = 0, M_CONV = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] start_v = '0, abort_v = '0, ready_v = '0, comp_v = '0;
  logic [1:0] busy_v, sample_v, strobe_v, valid_v;
  logic [N0-1:0] cap0, res0;
  logic [N1-1:0] cap1, res1;

  int unsigned vin[2]  = '{0, 0};
  int unsigned pn[2]   = '{N0, N1};
  int unsigned ps[2]   = '{S0, S1};
  int unsigned pt[2]   = '{T0, T1};
  int unsigned mode[2] = '{0, 0};
  int unsigned tc[2]   = '{0, 0};
  int unsigned cvin[2] = '{0, 0};
  int unsigned mres[2] = '{0, 0};

  int errors = 0;
  int checks = 0;
  int unsigned cap_log[16];

  sar_adc_ctrl #(.NBITS(N0), .SAMPLE_CYCLES(S0), .SETTLE_CYCLES(T0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .busy(busy_v[0]), .sample(sample_v[0]), .cap_drv(cap0), .comp_strobe(strobe_v[0]),
    .comp_out(comp_v[0]), .result(res0), .valid(valid_v[0]), .ready(ready_v[0])
  );

  sar_adc_ctrl #(.NBITS(N1), .SAMPLE_CYCLES(S1), .SETTLE_CYCLES(T1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .busy(busy_v[1]), .sample(sample_v[1]), .cap_drv(cap1), .comp_strobe(strobe_v[1]),
    .comp_out(comp_v[1]), .result(res1), .valid(valid_v[1]), .ready(ready_v[1])
  );

  initial forever #5 clk = ~clk;

  function automatic int unsigned cap_of(input int unsigned i);
    if (i == 0) return 32'(cap0);
    return 32'(cap1);
  endfunction

  function automatic int unsigned res_of(input int unsigned i);
    if (i == 0) return 32'(res0);
    return 32'(res1);
  endfunction

  function automatic int unsigned busy_len(input int unsigned i);
    return ps[i] + pn[i] * (pt[i] + 2);
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Expected outputs from the conversion timeline: S sampling cycles, then one
  // (T settle + strobe + latch) slot per bit, MSB first, with an ideal binary search.
  function automatic void expect_outs(input int unsigned i, output logic eb, output logic es,
                                      output logic est, output logic ev,
                                      output int unsigned ecap, output int unsigned eres);
    int unsigned off, k, b;
    eb = 1'b0; es = 1'b0; est = 1'b0; ev = 1'b0; ecap = 0; eres = mres[i];
    if (mode[i] == M_CONV) begin
      eb = 1'b1;
      if (tc[i] <= ps[i]) begin
        es = 1'b1;
      end else begin
        off  = tc[i] - ps[i] - 1;
        k    = off / (pt[i] + 2);
        b    = pn[i] - 1 - k;
        ecap = ((cvin[i] >> (b + 1)) << (b + 1)) | (32'd1 << b);
        est  = (off % (pt[i] + 2)) == pt[i];
      end
    end else if (mode[i] == M_DONE) begin
      ev   = 1'b1;
      ecap = cvin[i];
    end
  endfunction

  // Reference model: phase and cycle-within-conversion per instance.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mode[i] = M_IDLE; tc[i] = 0; mres[i] = 0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (abort_v[i]) mode[i] = M_IDLE;
        else if (mode[i] == M_IDLE) begin
          if (start_v[i]) begin mode[i] = M_CONV; tc[i] = 1; cvin[i] = vin[i]; end
        end else if (mode[i] == M_CONV) begin
          if (tc[i] == busy_len(i)) begin mode[i] = M_DONE; mres[i] = cvin[i]; end
          else tc[i] = tc[i] + 1;
        end else begin
          if (ready_v[i]) mode[i] = M_IDLE;
        end
      end
    end
  end

  // Ideal comparator: decision on vin >= DAC word during strobe, held through the
  // following cycle, random noise at all other times.
  initial begin
    bit hold[2];
    hold[0] = 1'b0; hold[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int unsigned i = 0; i < 2; i++) begin
        if (strobe_v[i]) begin
          comp_v[i] = (vin[i] >= cap_of(i));
          hold[i]   = 1'b1;
        end else if (hold[i]) begin
          hold[i] = 1'b0;
        end else begin
          comp_v[i] = 1'($urandom);
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial forever begin
    logic eb, es, est, ev;
    int unsigned ecap, eres;
    @(negedge clk);
    for (int unsigned i = 0; i < 2; i++) begin
      expect_outs(i, eb, es, est, ev, ecap, eres);
      chk($sformatf("dut%0d.busy", i),        32'(busy_v[i]),   32'(eb));
      chk($sformatf("dut%0d.sample", i),      32'(sample_v[i]), 32'(es));
      chk($sformatf("dut%0d.comp_strobe", i), 32'(strobe_v[i]), 32'(est));
      chk($sformatf("dut%0d.valid", i),       32'(valid_v[i]),  32'(ev));
      chk($sformatf("dut%0d.cap_drv", i),     cap_of(i),        ecap);
      chk($sformatf("dut%0d.result", i),      res_of(i),        eres);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start one conversion on instance sel (which must be idle) and measure it up to valid.
  task automatic conv(input int unsigned sel, input int unsigned v, input bit spam,
                      output int busy_n, output int valid_at, output int strb_n,
                      output int samp_n, output int ovl_n);
    busy_n = 0; valid_at = -1; strb_n = 0; samp_n = 0; ovl_n = 0;
    vin[sel] = v;
    start_v[sel] = 1'b1;
    cyc();
    start_v[sel] = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (valid_v[sel]) begin valid_at = c; break; end
      if (busy_v[sel]) busy_n++;
      if (strobe_v[sel]) begin
        if (strb_n < 16) cap_log[strb_n] = cap_of(sel);
        strb_n++;
      end
      if (sample_v[sel]) samp_n++;
      if (sample_v[sel] && cap_of(sel) != 0) ovl_n++;
      start_v[sel] = spam && (c == 5);
      cyc();
    end
    start_v[sel] = 1'b0;
    if (valid_at < 0) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    int bn, va, sn, pnum, ov;
    int unsigned exp_a5[8];
    int unsigned exp_b9[4];
    exp_a5 = '{32'h80, 32'hC0, 32'hA0, 32'hB0, 32'hA8, 32'hA4, 32'hA6, 32'hA5};
    exp_b9 = '{32'h8, 32'hC, 32'hA, 32'h9};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_busy", 32'(busy_v[0]), 0);
    chk("reset_valid", 32'(valid_v[0]), 0);
    chk("reset_result", res_of(0), 0);
    chk("reset_cap", cap_of(0), 0);
    cyc();

    // 0xA5 with start re-asserted mid-conversion; ready held low afterwards.
    conv(0, 32'hA5, 1'b1, bn, va, sn, pnum, ov);
    chk("a5_busy_cycles", 32'(bn), 26);
    chk("a5_valid_cycle", 32'(va), 27);
    chk("a5_strobes", 32'(sn), 8);
    chk("a5_sample_cycles", 32'(pnum), 2);
    chk("a5_overlap", 32'(ov), 0);
    chk("a5_result", res_of(0), 32'hA5);
    for (int unsigned k = 0; k < 8; k++) chk($sformatf("a5_trial%0d", k), cap_log[k], exp_a5[k]);
    for (int unsigned j = 0; j < 10; j++) begin
      start_v[0] = (j % 3 == 0);
      cyc();
      chk("done_hold_valid", 32'(valid_v[0]), 1);
      chk("done_hold_result", res_of(0), 32'hA5);
    end
    start_v[0] = 1'b0;
    ready_v[0] = 1'b1;
    cyc();
    ready_v[0] = 1'b0;
    chk("handshake_valid_low", 32'(valid_v[0]), 0);
    chk("handshake_busy_low", 32'(busy_v[0]), 0);

    conv(0, 32'h00, 1'b0, bn, va, sn, pnum, ov);
    chk("z_result", res_of(0), 0);
    chk("z_sample_cycles", 32'(pnum), 2);
    chk("z_overlap", 32'(ov), 0);
    ready_v[0] = 1'b1;
    cyc();

    // ready tied high: valid lasts exactly one cycle.
    conv(0, 32'hFF, 1'b0, bn, va, sn, pnum, ov);
    chk("ff_result", res_of(0), 32'hFF);
    chk("ff_sample_cycles", 32'(pnum), 2);
    chk("ff_overlap", 32'(ov), 0);
    cyc();
    chk("ff_valid_one_cycle", 32'(valid_v[0]), 0);
    ready_v[0] = 1'b0;

    // abort sampled at the end of conversion cycle 12.
    vin[0] = 32'h3C;
    start_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    repeat (11) cyc();
    abort_v[0] = 1'b1;
    cyc();
    abort_v[0] = 1'b0;
    chk("abort_busy", 32'(busy_v[0]), 0);
    chk("abort_sample", 32'(sample_v[0]), 0);
    chk("abort_cap", cap_of(0), 0);
    chk("abort_valid", 32'(valid_v[0]), 0);
    chk("abort_result", res_of(0), 32'hFF);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk("abort_start_busy", 32'(busy_v[0]), 0);
    chk("abort_start_sample", 32'(sample_v[0]), 0);

    // Parameter sweep instance.
    conv(1, 32'h9, 1'b0, bn, va, sn, pnum, ov);
    chk("b9_busy_cycles", 32'(bn), 19);
    chk("b9_valid_cycle", 32'(va), 20);
    chk("b9_strobes", 32'(sn), 4);
    chk("b9_sample_cycles", 32'(pnum), 3);
    chk("b9_result", res_of(1), 32'h9);
    for (int unsigned k = 0; k < 4; k++) chk($sformatf("b9_trial%0d", k), cap_log[k], exp_b9[k]);
    ready_v[1] = 1'b1;
    cyc();
    ready_v[1] = 1'b0;

    // Reset asserted during the first LATCH cycle (conversion cycle 5).
    vin[0] = 32'h5A;
    start_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    repeat (4) cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_cap", cap_of(0), 0);
    chk("rst_strobe", 32'(strobe_v[0]), 0);
    chk("rst_valid", 32'(valid_v[0]), 0);
    chk("rst_result_a", res_of(0), 0);
    chk("rst_result_b", res_of(1), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Randomized traffic on both instances.
    for (int unsigned n = 0; n < 3000; n++) begin
      for (int unsigned i = 0; i < 2; i++) begin
        start_v[i] = ($urandom % 4) == 0;
        abort_v[i] = ($urandom % 64) == 0;
        ready_v[i] = 1'($urandom);
        if (mode[i] == M_IDLE) vin[i] = $urandom & ((i == 0) ? 32'hFF : 32'hF);
      end
      cyc();
    end
    start_v = '0;
    abort_v = '0;
    ready_v = '0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
